thcattus_regbank_axilite_slave: RTL and testbench
=================================================

# thcattus_regbank_axilite_slave

Parametrised AXI-Lite register bank: the successor of the team's simple configuration slave. Provides NUM_REGS 32-bit registers with byte-strobe writes, per-register read-only (hardware status) mapping, proper OKAY/SLVERR/DECERR responses, and one-cycle write/read notification pulses. It sits between the AXI-Lite interconnect and block control/status logic.

## Interface

Parameters:
- NUM_REGS, 16, number of 32-bit registers (1..256)
- ADDR_WIDTH, 12, number of decoded address bits; must satisfy 2^(ADDR_WIDTH-2) >= NUM_REGS
- RO_MASK, {NUM_REGS{1'b0}}, bit i = 1 makes register i read-only, reading status_in word i

Ports (one clock; reset is synchronous and active-high):
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  synchronous active-high reset
- awaddr  in  32  write address; only [ADDR_WIDTH-1:2] decoded
- awprot  in  3  ignored
- awvalid / awready  in / out  1  write address handshake
- wdata  in  32  write data
- wstrb  in  4  byte enables, any pattern legal
- wvalid / wready  in / out  1  write data handshake
- bresp  out  2  write response
- bvalid / bready  out / in  1  write response handshake
- araddr  in  32  read address; only [ADDR_WIDTH-1:2] decoded
- arprot  in  3  ignored
- arvalid / arready  in / out  1  read address handshake
- rdata  out  32  read data
- rresp  out  2  read response
- rvalid / rready  out / in  1  read data handshake
- ctrl_out  out  NUM_REGS*32  register contents, word i at [32*i+31:32*i]; RO words read 0
- status_in  in  NUM_REGS*32  hardware values for RO registers; other words ignored
- wr_pulse  out  NUM_REGS  one-cycle pulse on successful write to register i
- rd_pulse  out  NUM_REGS  one-cycle pulse on read of register i (RW or RO)

## Operation

- Index = addr[ADDR_WIDTH-1:2]; addr[1:0] and bits above ADDR_WIDTH ignored.
- Write channel: AW and W accepted independently in any order; each captured into a holding register. awready = !aw_held && !bvalid && !areset; wready = !w_held && !bvalid && !areset.
- Commit: at the edge ending the cycle in which both AW and W are held-or-handshaking, the write is decoded and executed, holds cleared, bvalid set.
  - index >= NUM_REGS: no update, bresp = DECERR (2'b11).
  - RO_MASK[index] = 1: no update, bresp = SLVERR (2'b10).
  - else: byte k updated iff wstrb[k]; bresp = OKAY (2'b00); wr_pulse[index] = 1 for one cycle (also when wstrb = 0, with no data change).
- bvalid/bresp held until bready; bvalid cleared at the edge where bvalid && bready.
- Read channel: arready = !rvalid && !areset. On AR handshake, rdata/rresp/rvalid load at that edge.
  - index >= NUM_REGS: rdata = 0, rresp = DECERR.
  - RO: rdata = status_in word sampled at handshake edge, rresp = OKAY.
  - RW: rdata = register value before any same-edge write, rresp = OKAY.
  - rd_pulse[index] = 1 for one cycle (not for DECERR).
- rdata/rresp stable while rvalid && !rready.
- Read and write channels fully independent; simultaneous write commit and read of same register returns old value.

## Timing

- Reset (areset = 1 at edge): all registers 0, holds cleared, bvalid = rvalid = 0, bresp = rresp = 0, rdata = 0, wr_pulse = rd_pulse = 0; awready/wready/arready = 0 while areset is high, 1 in first cycle after.
- Reset mid-transaction discards held AW/W and any pending response; no response is ever issued for it.
- Write latency: last handshake in cycle t -> bvalid, ctrl_out update, wr_pulse in cycle t+1.
- Write throughput: bready held high -> one write per 2 cycles.
- Read latency: AR handshake in cycle t -> rvalid, rd_pulse in t+1; with rready high, arready returns in t+2.
- No combinational path from any AXI input to any AXI output, except areset gating on ready signals.

## Test plan

- Reset then write 0xDEADBEEF to 0x008 (wstrb 4'hF, AW and W same cycle) -> bvalid in next cycle, bresp OKAY, ctrl_out word 2 = 0xDEADBEEF, wr_pulse[2] one cycle; read 0x008 -> rdata 0xDEADBEEF, rresp OKAY, rd_pulse[2].
- W issued 3 cycles before AW, wstrb 4'b0101, data 0x11223344 over 0xDEADBEEF -> word = 0xDE22BE44; wready low after W until bvalid handshake.
- NUM_REGS = 16, RO_MASK bit 5 set, status_in word 5 = 0xCAFE0001: write 0x014 -> SLVERR, no wr_pulse; read 0x014 -> 0xCAFE0001 OKAY.
- Write/read 0x040 (index 16) -> DECERR both, rdata 0, no pulses, no register change.
- bready/rready held low 10 cycles -> bvalid/rvalid, bresp/rdata stable; awready/wready/arready low throughout.
- Assert areset with AW held and W pending -> after reset all outputs at reset values, no bvalid ever, next write completes normally.

Source files
------------

// File: rtl/thcattus_regbank_axilite_slave_if.sv
// AXI-Lite bus bundle for the register bank.
// master: drives AW/W/AR address/data/valid and bready/rready.
// slave : drives awready/wready/arready, B response and R data/response.
interface thcattus_regbank_axilite_slave_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/thcattus_regbank_axilite_slave.sv
// AXI-Lite register bank: NUM_REGS 32-bit registers, byte-strobe writes,
// read-only status words selected by RO_MASK, OKAY/SLVERR/DECERR responses
// and one-cycle write/read notification pulses.
// Ports:
//   aclk, areset  clock and synchronous active-high reset
//   axi           AXI-Lite slave port (AW, W, B, AR, R channels)
//   ctrl_out      register contents, word i at [32*i+31:32*i]; RO words 0
//   status_in     hardware values returned for RO words
//   wr_pulse      one-cycle pulse per register on successful write
//   rd_pulse      one-cycle pulse per register on read (RW or RO)
module thcattus_regbank_axilite_slave #(
  parameter int                  NUM_REGS   = 16,
  parameter int                  ADDR_WIDTH = 12,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           aclk,
  input  logic                           areset,
  thcattus_regbank_axilite_slave_if.slave axi,
  output logic [NUM_REGS*32-1:0]         ctrl_out,
  input  logic [NUM_REGS*32-1:0]         status_in,
  output logic [NUM_REGS-1:0]            wr_pulse,
  output logic [NUM_REGS-1:0]            rd_pulse
);

  localparam int         IDXW   = ADDR_WIDTH - 2;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // write side state
  logic                     aw_held_q, aw_held_d;
  logic [IDXW-1:0]          awidx_q, awidx_d;
  logic                     w_held_q, w_held_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [3:0]               wstrb_q, wstrb_d;
  logic                     bvalid_q, bvalid_d;
  logic [1:0]               bresp_q, bresp_d;
  logic [NUM_REGS-1:0][31:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]      wr_pulse_q, wr_pulse_d;

  // read side state
  logic                     rvalid_q, rvalid_d;
  logic [31:0]              rdata_q, rdata_d;
  logic [1:0]               rresp_q, rresp_d;
  logic [NUM_REGS-1:0]      rd_pulse_q, rd_pulse_d;

  logic            aw_hs, w_hs, ar_hs, commit;
  logic [IDXW-1:0] w_idx, r_idx;
  logic [31:0]     w_dat;
  logic [3:0]      w_stb;

  // prot bits, sub-word and above-window address bits are don't-care
  logic unused_ok;
  assign unused_ok = ^{axi.awprot, axi.arprot,
                       axi.awaddr[31:ADDR_WIDTH], axi.awaddr[1:0],
                       axi.araddr[31:ADDR_WIDTH], axi.araddr[1:0]};

  // readys depend only on state and reset: no AXI input-to-output comb path
  assign axi.awready = !aw_held_q && !bvalid_q && !areset;
  assign axi.wready  = !w_held_q  && !bvalid_q && !areset;
  assign axi.arready = !rvalid_q  && !areset;

  assign aw_hs  = axi.awvalid && axi.awready;
  assign w_hs   = axi.wvalid  && axi.wready;
  assign ar_hs  = axi.arvalid && axi.arready;
  assign commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);

  // a held beat takes priority over the live bus (live one isn't accepted)
  assign w_idx = aw_held_q ? awidx_q : axi.awaddr[ADDR_WIDTH-1:2];
  assign w_dat = w_held_q  ? wdata_q : axi.wdata;
  assign w_stb = w_held_q  ? wstrb_q : axi.wstrb;
  assign r_idx = axi.araddr[ADDR_WIDTH-1:2];

  always_comb begin
    aw_held_d  = aw_held_q;
    awidx_d    = awidx_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
    if (bvalid_q && axi.bready) bvalid_d = 1'b0;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = DECERR;     // overridden below if the index decodes
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_idx == IDXW'(i)) begin
          if (RO_MASK[i]) begin
            bresp_d = SLVERR;
          end else begin
            bresp_d       = OKAY;
            wr_pulse_d[i] = 1'b1;
            for (int b = 0; b < 4; b++)
              if (w_stb[b]) regs_d[i][8*b +: 8] = w_dat[8*b +: 8];
          end
        end
      end
    end else begin
      if (aw_hs) begin
        aw_held_d = 1'b1;
        awidx_d   = axi.awaddr[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        wdata_d  = axi.wdata;
        wstrb_d  = axi.wstrb;
      end
    end
  end

  // read returns regs_q, i.e. the value before any same-edge write commit
  always_comb begin
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_pulse_d = '0;
    if (rvalid_q && axi.rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = DECERR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (r_idx == IDXW'(i)) begin
          rresp_d       = OKAY;
          rd_pulse_d[i] = 1'b1;
          rdata_d       = RO_MASK[i] ? status_in[32*i +: 32] : regs_q[i];
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_held_q  <= 1'b0;
      awidx_q    <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      regs_q     <= '0;
      wr_pulse_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      rd_pulse_q <= '0;
    end else begin
      aw_held_q  <= aw_held_d;
      awidx_q    <= awidx_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rd_pulse_q <= rd_pulse_d;
    end
  end

  assign axi.bvalid = bvalid_q;
  assign axi.bresp  = bresp_q;
  assign axi.rvalid = rvalid_q;
  assign axi.rdata  = rdata_q;
  assign axi.rresp  = rresp_q;
  assign ctrl_out   = regs_q;
  assign wr_pulse   = wr_pulse_q;
  assign rd_pulse   = rd_pulse_q;

endmodule

// File: tb/tb_thcattus_regbank_axilite_slave.sv
// Directed bench for thcattus_regbank_axilite_slave: 16 registers, word 5
// read-only. Drives the AXI-Lite interface, checks responses, pulses and
// ctrl_out against hand-computed values.
module tb_thcattus_regbank_axilite_slave;
  localparam int NR = 16;

  logic           aclk = 1'b0;
  logic           areset;
  logic [NR*32-1:0] ctrl_out;
  logic [NR*32-1:0] status_in;
  logic [NR-1:0]  wr_pulse, rd_pulse;
  logic [31:0]    m [NR];   // expected register contents
  int             n_cmp = 0, n_err = 0;

  thcattus_regbank_axilite_slave_if axi();

  thcattus_regbank_axilite_slave #(
    .NUM_REGS(NR), .ADDR_WIDTH(12), .RO_MASK(16'h0020)
  ) dut (
    .aclk(aclk), .areset(areset), .axi(axi),
    .ctrl_out(ctrl_out), .status_in(status_in),
    .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk); #1;
  endtask

  task automatic chk_regs(input string tg);
    for (int i = 0; i < NR; i++)
      chk($sformatf("%s_word%0d", tg, i), ctrl_out[32*i +: 32], m[i]);
  endtask

  // W is presented w_lead cycles before AW; bready held low b_hold cycles
  task automatic axi_wr(input string tg, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int w_lead, input int b_hold,
                        input logic [1:0] exp_resp, input logic [15:0] exp_pulse);
    bit aw_d = 0, w_d = 0, ah, wh;
    int cyc = 0;
    axi.awaddr = addr; axi.wdata = data; axi.wstrb = strb; axi.wvalid = 1'b1;
    while (!(aw_d && w_d) && cyc < 40) begin
      if (cyc == w_lead) axi.awvalid = 1'b1;
      ah = axi.awvalid && axi.awready;
      wh = axi.wvalid && axi.wready;
      step();
      if (ah) begin axi.awvalid = 1'b0; aw_d = 1; end
      if (wh) begin axi.wvalid = 1'b0; w_d = 1; end
      if (w_d && !aw_d) chk({tg, "_wready_low"}, axi.wready, 0);
      cyc++;
    end
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    chk({tg, "_bvalid"}, axi.bvalid, 1);
    chk({tg, "_bresp"}, axi.bresp, exp_resp);
    chk({tg, "_wr_pulse"}, wr_pulse, exp_pulse);
    for (int i = 0; i < b_hold; i++) begin
      step();
      chk({tg, "_hold_bvalid"}, axi.bvalid, 1);
      chk({tg, "_hold_bresp"}, axi.bresp, exp_resp);
      chk({tg, "_hold_ready"}, {axi.awready, axi.wready}, 0);
    end
    axi.bready = 1'b1;
    step();
    axi.bready = 1'b0;
    chk({tg, "_bvalid_clr"}, axi.bvalid, 0);
    chk({tg, "_wr_pulse_clr"}, wr_pulse, 0);
  endtask

  task automatic axi_rd(input string tg, input logic [31:0] addr, input int r_hold,
                        input logic [31:0] exp_data, input logic [1:0] exp_resp,
                        input logic [15:0] exp_pulse);
    bit done = 0, h;
    int cyc = 0;
    axi.araddr = addr; axi.arvalid = 1'b1;
    while (!done && cyc < 40) begin
      h = axi.arvalid && axi.arready;
      step();
      if (h) begin axi.arvalid = 1'b0; done = 1; end
      cyc++;
    end
    axi.arvalid = 1'b0;
    chk({tg, "_rvalid"}, axi.rvalid, 1);
    chk({tg, "_rdata"}, axi.rdata, exp_data);
    chk({tg, "_rresp"}, axi.rresp, exp_resp);
    chk({tg, "_rd_pulse"}, rd_pulse, exp_pulse);
    for (int i = 0; i < r_hold; i++) begin
      step();
      chk({tg, "_hold_rvalid"}, axi.rvalid, 1);
      chk({tg, "_hold_rdata"}, axi.rdata, exp_data);
      chk({tg, "_hold_arready"}, axi.arready, 0);
    end
    axi.rready = 1'b1;
    step();
    axi.rready = 1'b0;
    chk({tg, "_rvalid_clr"}, axi.rvalid, 0);
    chk({tg, "_rd_pulse_clr"}, rd_pulse, 0);
    chk({tg, "_arready_back"}, axi.arready, 1);
  endtask

  initial begin
    areset = 1'b1;
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    status_in = '0;
    status_in[32*5 +: 32] = 32'hCAFE0001;
    for (int i = 0; i < NR; i++) m[i] = '0;

    // reset state
    step(); step(); step();
    chk("rst_readys", {axi.awready, axi.wready, axi.arready}, 0);
    chk("rst_valids", {axi.bvalid, axi.rvalid}, 0);
    chk("rst_resp", {axi.bresp, axi.rresp, axi.rdata}, 0);
    chk("rst_pulses", {wr_pulse, rd_pulse}, 0);
    chk_regs("rst");
    areset = 1'b0;
    #1;
    chk("post_rst_readys", {axi.awready, axi.wready, axi.arready}, 3'b111);

    // full write, AW and W together; read back
    axi_wr("w2", 32'h008, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00, 16'h0004);
    m[2] = 32'hDEADBEEF;
    chk_regs("w2");
    axi_rd("r2", 32'h008, 0, 32'hDEADBEEF, 2'b00, 16'h0004);

    // W three cycles ahead of AW, partial strobe
    axi_wr("w2s", 32'h008, 32'h11223344, 4'b0101, 3, 0, 2'b00, 16'h0004);
    m[2] = 32'hDE22BE44;
    chk_regs("w2s");

    // read-only word 5
    axi_wr("wro", 32'h014, 32'h55555555, 4'hF, 0, 0, 2'b10, 16'h0000);
    chk_regs("wro");
    axi_rd("rro", 32'h014, 0, 32'hCAFE0001, 2'b00, 16'h0020);

    // out-of-range index 16
    axi_wr("wdec", 32'h040, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b11, 16'h0000);
    chk_regs("wdec");
    axi_rd("rdec", 32'h040, 0, 32'h0, 2'b11, 16'h0000);

    // zero strobe still pulses, changes nothing
    axi_wr("wz", 32'h00C, 32'hFFFFFFFF, 4'h0, 0, 0, 2'b00, 16'h0008);
    chk_regs("wz");

    // address bits above the window and below the word are ignored
    axi_rd("ralias", 32'h100A, 0, 32'hDE22BE44, 2'b00, 16'h0004);

    // back-pressure on B and R for 10 cycles
    axi_wr("wstall", 32'h010, 32'hA5A5A5A5, 4'hF, 0, 10, 2'b00, 16'h0010);
    m[4] = 32'hA5A5A5A5;
    axi_rd("rstall", 32'h010, 10, 32'hA5A5A5A5, 2'b00, 16'h0010);

    // reset with AW held and W pending
    axi.awaddr = 32'h018; axi.awvalid = 1'b1;
    step();
    axi.awvalid = 1'b0;
    chk("mid_aw_held", axi.awready, 0);
    axi.wdata = 32'h77777777; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    areset = 1'b1;
    step();
    axi.wvalid = 1'b0;
    chk("mid_rst_bvalid", axi.bvalid, 0);
    step();
    areset = 1'b0;
    for (int i = 0; i < NR; i++) m[i] = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_post_bvalid", axi.bvalid, 0);
      chk("mid_post_readys", {axi.awready, axi.wready, axi.arready}, 3'b111);
      chk("mid_post_pulses", {wr_pulse, rd_pulse}, 0);
    end
    chk_regs("mid");
    axi_wr("wpost", 32'h018, 32'h0BADF00D, 4'hF, 0, 0, 2'b00, 16'h0040);
    m[6] = 32'h0BADF00D;
    chk_regs("wpost");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
